conv_result_drain: RTL and testbench
====================================

// Module: conv_result_drain
// PURPOSE
// - Reader at the far end of the accelerator output memory: the control unit writes results, this block reads them back.
// - On start (tied to the control unit's done), reads NUM_OUT words from output memory at addresses 0..NUM_OUT-1.
// - Streams the words to the host over a valid/ready interface, with m_last on the final word.
// - Sits between the output memory read port and the host interface, beside the control unit in top.
// PARAMETERS
// - DATA_W   32  width of one output-memory word / stream beat
// - ADDR_W   4   output-memory address width
// - NUM_OUT  9   result words per frame (3x3 result of 5x5 input, 3x3 kernel); 1 <= NUM_OUT <= 2**ADDR_W
// PORTS
// - clk         in   1       clock; all logic on rising edge
// - rst         in   1       asynchronous, active-low reset
// - start       in   1       one-cycle pulse: begin draining a frame (connect to done)
// - en_out_mem  out  1       output-memory enable; asserted only on read-issue cycles
// - rw_out_mem  out  1       output-memory direction; constant 0 (read)
// - out_addr    out  ADDR_W  output-memory read address
// - out_rdata   in   DATA_W  read data, valid exactly 1 cycle after the en_out_mem cycle
// - m_data      out  DATA_W  stream data
// - m_valid     out  1       stream valid
// - m_ready     in   1       stream ready from host
// - m_last      out  1       high with m_valid on beat NUM_OUT-1
// - busy        out  1       high from the cycle after start until drained
// - drained     out  1       one-cycle pulse after the last beat handshake
// BEHAVIOUR
// - Reset values: en_out_mem=0, rw_out_mem=0, out_addr=0, m_data=0, m_valid=0, m_last=0, busy=0, drained=0.
// - FSM states IDLE, READ, FLUSH, FIN.
//   IDLE  -> READ on start; read counter and beat counter clear to 0.
//   READ  -> FLUSH on the cycle the NUM_OUT-th read is issued.
//   FLUSH -> FIN on m_valid&m_ready&m_last.
//   FIN   -> IDLE after one cycle; drained=1 for that cycle only.
// - start outside IDLE is ignored; no queuing.
// - A read is issued when free_entries - inflight >= 1, where free_entries counts the 2-entry buffer and inflight (0/1) is the previous cycle's read.
// - A full buffer plus m_ready=0 stalls issue. Data is never dropped or duplicated.
// - out_addr increments only on issue cycles; no wrap within a frame. It returns to 0 on entering IDLE.
// - Handshake: a beat transfers when m_valid&m_ready.
//   - m_data, m_valid and m_last hold stable while m_valid=1 and m_ready=0.
//   - m_valid may not depend combinationally on m_ready.
// - Latency: first m_valid is 3 cycles after the start pulse (IDLE->READ, issue, capture). With m_ready held at 1, a frame takes NUM_OUT+3 cycles start-to-drained.
// - m_last = (beat counter == NUM_OUT-1) & m_valid.
// - Beat counter width is $clog2(NUM_OUT+1). Read counter width is ADDR_W+1, so NUM_OUT = 2**ADDR_W has no overflow.
// - Reset asserted mid-frame: immediately return to IDLE, flush the buffer, drop the in-flight read, deassert all outputs.
// - Simultaneous buffer push and pop at full occupancy is legal; occupancy is unchanged.
// CONFIGURATION
// - CONV_DRAIN_RELU_EN defined: the captured word is treated as signed. If bit DATA_W-1 is 1, the word is replaced by 0 before buffering. The zeroing is applied at capture and adds no latency.
// - CONV_DRAIN_RELU_EN undefined: words pass through unmodified.
// STRUCTURE
// - Package conv_pkg holds:
//   - drain state enum (IDLE/READ/FLUSH/FIN)
//   - RW_READ=1'b0 and RW_WRITE=1'b1 constants, shared with the control unit
//   - default DATA_W/ADDR_W/NUM_OUT constants
// - One sub-module, drain_skid_fifo: a 2-entry FIFO (DATA_W+1 bits: data, last) with push/pop/full/empty/count. Its output registers drive m_data/m_valid/m_last.
// - Top of the block: FSM, read-issue credit logic, counters, optional ReLU stage.
// TESTING
// - Continuous drain: memory preloaded with 0x10..0x18, start pulse, m_ready=1.
//   Expect 9 beats 0x10..0x18 in order, m_last only on 0x18, drained exactly 12 cycles after start.
// - Backpressure: m_ready toggled 1,0,0,1 repeating.
//   Expect the same 9 beats, data stable during every stall, en_out_mem never asserted with 2 entries occupied plus 1 in flight.
// - Reset mid-frame: rst driven low after beat 4.
//   Expect all outputs 0 asynchronously. After release, a new start drains all 9 words from address 0.
// - Ignored start: second start pulse during beat 2.
//   Expect exactly 9 beats and a single drained pulse.
// - Boundary: NUM_OUT=16, ADDR_W=4, data = address.
//   Expect addresses 0..15 issued, no wrap to 0 mid-frame, m_last on data 15.
// - ReLU: CONV_DRAIN_RELU_EN defined, memory holds 0xFFFFFFF0 and 0x00000007.
//   Expect beats 0x00000000 and 0x00000007. Without the macro, expect 0xFFFFFFF0 and 0x00000007.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution accelerator output path.
// Holds the drain FSM state encoding and the memory direction codes used by the control unit.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    FIN   = 2'd3
  } drain_state_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 4;
  localparam int DEF_NUM_OUT = 9;

endpackage

// File: rtl/drain_skid_fifo.sv
// 2-entry FIFO whose head register directly drives the output stream.
// Latency: 1 cycle push-to-head; backpressure: push and pop together at full occupancy is legal.
module drain_skid_fifo #(
  parameter int W = 33
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic [1:0]   r_count;
  logic         w_pop;
  logic         w_push;

  assign w_pop  = i_pop & (r_count != 2'd0);
  assign w_push = i_push & ((r_count != 2'd2) | w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_din;
          else                 r_tail <= i_din;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; the new word lands behind whatever remains
          if (r_count == 2'd1) begin
            r_head <= i_din;
          end else begin
            r_head <= r_tail;
            r_tail <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_dout  = r_head;
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/conv_result_drain.sv
// Drains NUM_OUT result words from output memory to a valid/ready host stream (ReLU option: CONV_DRAIN_RELU_EN).
// Latency: first beat 3 cycles after start; NUM_OUT+3 cycles start-to-drained at full rate.
// Backpressure: reads are credit-issued into a 2-entry skid FIFO, so nothing is dropped while m_ready is low.
module conv_result_drain
  import conv_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_OUT = DEF_NUM_OUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              en_out_mem,
  output logic              rw_out_mem,
  output logic [ADDR_W-1:0] out_addr,
  input  logic [DATA_W-1:0] out_rdata,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              drained
);

  localparam int BEAT_W = $clog2(NUM_OUT + 1);
  localparam int RCNT_W = ADDR_W + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_OUT - 1);
  localparam logic [RCNT_W-1:0] LAST_READ = RCNT_W'(NUM_OUT - 1);

  drain_state_e r_state;
  drain_state_e w_state_nxt;

  logic [RCNT_W-1:0] r_rd_cnt;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic              r_inflight;
  logic              r_inflight_last;

  logic              w_start_frame;
  logic              w_issue;
  logic              w_credit;
  logic              w_pop;
  logic              w_beat_last;
  logic [DATA_W-1:0] w_cap_data;
  logic [DATA_W:0]   w_fifo_dout;
  logic              w_full;
  logic              w_empty;
  logic [1:0]        w_count;

  assign w_start_frame = (r_state == IDLE) & start;
  assign w_pop         = m_valid & m_ready;
  assign w_beat_last   = (r_beat_cnt == LAST_BEAT);

  // Buffered words plus the read already in flight must leave room for one more,
  // counting the slot freed by a pop this cycle.
  assign w_credit = ({1'b0, w_count} + {2'b00, r_inflight}) <= (3'd1 + {2'b00, w_pop});
  assign w_issue  = (r_state == READ) & w_credit & ~(w_full & ~w_pop);

`ifdef CONV_DRAIN_RELU_EN
  assign w_cap_data = out_rdata[DATA_W-1] ? '0 : out_rdata;
`else
  assign w_cap_data = out_rdata;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = READ;
      READ:    if (w_issue && (r_rd_cnt == LAST_READ)) w_state_nxt = FLUSH;
      FLUSH:   if (w_pop && w_beat_last) w_state_nxt = FIN;
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_cnt        <= '0;
      r_beat_cnt      <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue & (r_rd_cnt == LAST_READ);
      // clearing in FIN parks the address at 0 for the whole IDLE period
      if (w_start_frame || (r_state == FIN)) begin
        r_rd_cnt   <= '0;
        r_beat_cnt <= '0;
      end else begin
        if (w_issue) r_rd_cnt   <= r_rd_cnt + RCNT_W'(1);
        if (w_pop)   r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
      end
    end
  end

  drain_skid_fifo #(
    .W (DATA_W + 1)
  ) u_skid (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_push  (r_inflight),
    .i_din   ({r_inflight_last, w_cap_data}),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign en_out_mem = w_issue;
  assign rw_out_mem = RW_READ;
  assign out_addr   = r_rd_cnt[ADDR_W-1:0];
  assign m_data     = w_fifo_dout[DATA_W-1:0];
  assign m_valid    = ~w_empty;
  assign m_last     = w_fifo_dout[DATA_W] & m_valid;
  assign busy       = (r_state != IDLE);
  assign drained    = (r_state == FIN);

endmodule

// File: tb/tb_conv_result_drain.sv
// Directed bench for conv_result_drain: default 9-word instance plus a 16-word boundary instance.
`timescale 1ns/1ps
module tb_conv_result_drain;

  localparam int DW = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start, en, rw, m_valid, m_ready, m_last, busy, drained;
  logic [AW-1:0] addr;
  logic [DW-1:0] rdata, m_data;
  logic [DW-1:0] mem [16];

  logic          start16, en16, rw16, mv16, mr16, ml16, busy16, dr16;
  logic [AW-1:0] addr16;
  logic [DW-1:0] rdata16, md16;

  conv_result_drain dut (
    .clk(clk), .rst(rst), .start(start), .en_out_mem(en), .rw_out_mem(rw),
    .out_addr(addr), .out_rdata(rdata), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy), .drained(drained)
  );

  conv_result_drain #(.DATA_W(DW), .ADDR_W(AW), .NUM_OUT(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .en_out_mem(en16), .rw_out_mem(rw16),
    .out_addr(addr16), .out_rdata(rdata16), .m_data(md16), .m_valid(mv16),
    .m_ready(mr16), .m_last(ml16), .busy(busy16), .drained(dr16)
  );

  // Synchronous-read memory models: data valid the cycle after the enable cycle.
  always @(posedge clk) if (en && !rw) rdata <= mem[addr];
  always @(posedge clk) if (en16) rdata16 <= {{(DW-AW){1'b0}}, addr16};

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stream monitor for the 9-word instance.
  logic [DW-1:0] q[$];
  logic          lq[$];
  logic [AW-1:0] aq[$];
  int pend = 0, stab_err = 0, credit_err = 0, stall_cnt = 0, drain_cnt = 0, drain_cyc = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      pend = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !(m_valid && m_data === prev_data && m_last === prev_last)) stab_err++;
      if (en && (pend - ((m_valid && m_ready) ? 1 : 0)) > 1) credit_err++;
      if (en) aq.push_back(addr);
      if (m_valid && m_ready) begin
        q.push_back(m_data);
        lq.push_back(m_last);
      end
      if (m_valid && !m_ready) stall_cnt++;
      if (drained) begin
        drain_cnt++;
        drain_cyc = cyc;
      end
      pend += (en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  logic [DW-1:0] q16[$];
  logic          lq16[$];
  logic [AW-1:0] aq16[$];
  int dr16_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      if (en16) aq16.push_back(addr16);
      if (mv16 && mr16) begin
        q16.push_back(md16);
        lq16.push_back(ml16);
      end
      if (dr16) dr16_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses start and runs until drained; mode 0 = ready held high, mode 1 = ready 1,0,0,1.
  task automatic run_frame(input int mode, input int restart_at, output bit timeout);
    int base, d0;
    bit restarted;
    logic [3:0] pat;
    pat = 4'b1001;
    base = q.size();
    d0 = drain_cnt;
    timeout = 1'b1;
    restarted = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    m_ready = 1'b1;
    start_cyc = cyc;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (restart_at >= 0 && !restarted && (q.size() - base) == restart_at) begin
        start = 1'b1;
        restarted = 1'b1;
      end
      m_ready = (mode == 0) ? 1'b1 : pat[k % 4];
      if (drain_cnt != d0) begin
        timeout = 1'b0;
        break;
      end
    end
    start = 1'b0;
    m_ready = 1'b1;
  endtask

  // Expects n beats of data0+i with m_last only on the final one, issued from address 0 upward.
  task automatic check_frame(input string tag, input int base, input int abase, input int n, input logic [DW-1:0] data0);
    chk({tag, "_nbeats"}, 64'(q.size() - base), 64'(n));
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_beat%0d", tag, i), (base + i < q.size()) ? 64'(q[base + i]) : 64'hDEAD, 64'(data0 + DW'(i)));
      chk($sformatf("%s_last%0d", tag, i), (base + i < lq.size()) ? 64'(lq[base + i]) : 64'hDEAD, 64'(i == n - 1));
      chk($sformatf("%s_addr%0d", tag, i), (abase + i < aq.size()) ? 64'(aq[abase + i]) : 64'hDEAD, 64'(i));
    end
  endtask

  initial begin
    int base, abase, d0, s0, c0, st0, b16, a16;
    bit to;
    logic [DW-1:0] relu_exp;

    rst = 1'b0;
    start = 1'b0;
    m_ready = 1'b1;
    start16 = 1'b0;
    mr16 = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 32'h10 + DW'(i);
    #8;
    chk("rst_en", 64'(en), 0);
    chk("rst_rw", 64'(rw), 0);
    chk("rst_addr", 64'(addr), 0);
    chk("rst_mdata", 64'(m_data), 0);
    chk("rst_mvalid", 64'(m_valid), 0);
    chk("rst_mlast", 64'(m_last), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_drained", 64'(drained), 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    // Continuous drain at full rate.
    base = q.size(); abase = aq.size(); d0 = drain_cnt;
    run_frame(0, -1, to);
    chk("cont_timeout", 64'(to), 0);
    check_frame("cont", base, abase, 9, 32'h10);
    chk("cont_latency", 64'(drain_cyc - start_cyc), 12);
    chk("cont_ndrained", 64'(drain_cnt - d0), 1);
    chk("cont_busy_after", 64'(busy), 0);
    chk("cont_addr_idle", 64'(addr), 0);

    // Backpressure with ready pattern 1,0,0,1.
    base = q.size(); abase = aq.size(); s0 = stab_err; c0 = credit_err; st0 = stall_cnt;
    run_frame(1, -1, to);
    chk("bp_timeout", 64'(to), 0);
    check_frame("bp", base, abase, 9, 32'h10);
    chk("bp_stable", 64'(stab_err - s0), 0);
    chk("bp_credit", 64'(credit_err - c0), 0);
    chk("bp_stalls_seen", 64'(stall_cnt - st0 > 0), 1);

    // Reset asserted after the fourth beat.
    base = q.size();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (q.size() - base >= 4) break;
      @(posedge clk); #1;
    end
    chk("mid_reached_beat4", 64'(q.size() - base >= 4), 1);
    chk("mid_busy_before", 64'(busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_en", 64'(en), 0);
    chk("mid_addr", 64'(addr), 0);
    chk("mid_mdata", 64'(m_data), 0);
    chk("mid_mvalid", 64'(m_valid), 0);
    chk("mid_mlast", 64'(m_last), 0);
    chk("mid_busy", 64'(busy), 0);
    chk("mid_drained", 64'(drained), 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    base = q.size(); abase = aq.size(); d0 = drain_cnt;
    run_frame(0, -1, to);
    chk("post_rst_timeout", 64'(to), 0);
    check_frame("post_rst", base, abase, 9, 32'h10);
    chk("post_rst_ndrained", 64'(drain_cnt - d0), 1);

    // Second start during beat 2 must be ignored.
    base = q.size(); abase = aq.size(); d0 = drain_cnt;
    run_frame(0, 2, to);
    chk("ign_timeout", 64'(to), 0);
    repeat (20) @(posedge clk);
    #1;
    chk("ign_nbeats", 64'(q.size() - base), 9);
    chk("ign_ndrained", 64'(drain_cnt - d0), 1);
    chk("ign_busy_after", 64'(busy), 0);

    // ReLU on captured words.
    mem[0] = 32'hFFFF_FFF0;
    mem[1] = 32'h0000_0007;
`ifdef CONV_DRAIN_RELU_EN
    relu_exp = 32'h0000_0000;
`else
    relu_exp = 32'hFFFF_FFF0;
`endif
    base = q.size();
    run_frame(0, -1, to);
    chk("relu_timeout", 64'(to), 0);
    chk("relu_beat0", (base < q.size()) ? 64'(q[base]) : 64'hDEAD, 64'(relu_exp));
    chk("relu_beat1", (base + 1 < q.size()) ? 64'(q[base + 1]) : 64'hDEAD, 64'h7);

    // Boundary: 16 words filling the whole address space.
    b16 = q16.size(); a16 = aq16.size(); d0 = dr16_cnt;
    @(posedge clk); #1 start16 = 1'b1;
    @(posedge clk); #1 start16 = 1'b0;
    chk("b16_busy", 64'(busy16), 1);
    chk("b16_rw", 64'(rw16), 0);
    for (int k = 0; k < 200; k++) begin
      if (dr16_cnt != d0) break;
      @(posedge clk); #1;
    end
    chk("b16_ndrained", 64'(dr16_cnt - d0), 1);
    chk("b16_nbeats", 64'(q16.size() - b16), 16);
    chk("b16_naddr", 64'(aq16.size() - a16), 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("b16_addr%0d", i), (a16 + i < aq16.size()) ? 64'(aq16[a16 + i]) : 64'hDEAD, 64'(i));
      chk($sformatf("b16_beat%0d", i), (b16 + i < q16.size()) ? 64'(q16[b16 + i]) : 64'hDEAD, 64'(i));
      chk($sformatf("b16_last%0d", i), (b16 + i < lq16.size()) ? 64'(lq16[b16 + i]) : 64'hDEAD, 64'(i == 15));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
